// File: rtl/pc_unit_ras_if.sv
// Fetch-side bundle for pc_unit_ras: control/hint inputs in, fetch address and RAS status out.
interface pc_unit_ras_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  logic                           start_i;
  logic                           stall_i;
  logic                           redirect_i;
  logic [XLEN-1:0]                redirect_pc_i;
  logic                           trap_i;
  logic                           call_i;
  logic                           ret_i;
  logic [XLEN-1:0]                pc_o;
  logic                           pc_valid_o;
  logic [$clog2(RAS_DEPTH):0]     ras_count_o;
  logic                           ras_empty_o;
  logic                           ras_full_o;

  modport master (
    output start_i, stall_i, redirect_i, redirect_pc_i, trap_i, call_i, ret_i,
    input  pc_o, pc_valid_o, ras_count_o, ras_empty_o, ras_full_o
  );

  modport slave (
    input  start_i, stall_i, redirect_i, redirect_pc_i, trap_i, call_i, ret_i,
    output pc_o, pc_valid_o, ras_count_o, ras_empty_o, ras_full_o
  );
endinterface

// File: rtl/pc_unit_ras.sv
// IF-stage program counter with priority next-PC selection and a circular return-address stack.
module pc_unit_ras #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int              STEP      = 4,
  parameter int              RAS_DEPTH = 4
) (
  input logic              clk_i,
  input logic              rst_n_i,
  pc_unit_ras_if.slave     bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  r_pc;
  logic             r_pc_valid;
  logic [PTR_W-1:0] r_ptr;    // next free slot; top of stack is r_ptr-1
  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  r_ras [RAS_DEPTH];

  logic [XLEN-1:0]  w_pc_seq;
  logic [XLEN-1:0]  w_redirect_pc;
  logic [PTR_W-1:0] w_top_idx;
  logic             w_flow;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic [PTR_W-1:0] w_waddr;

  assign w_pc_seq      = r_pc + XLEN'(STEP);
  assign w_redirect_pc = bus.redirect_pc_i & ~XLEN'(STEP - 1);
  assign w_top_idx     = r_ptr - PTR_W'(1);
  assign w_full        = (r_count == CNT_W'(RAS_DEPTH));

  // Normal flow: running and not overridden by trap, redirect or stall.
  assign w_flow  = bus.start_i & ~bus.trap_i & ~bus.redirect_i & ~bus.stall_i;
  assign w_pop   = w_flow & bus.ret_i & (r_count != '0);
  assign w_push  = w_flow & bus.call_i;
  // A call paired with a pop rewrites the popped slot instead of a new one.
  assign w_waddr = w_pop ? w_top_idx : r_ptr;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pc       <= RESET_PC;
      r_pc_valid <= 1'b0;
      r_ptr      <= '0;
      r_count    <= '0;
    end else if (!bus.start_i) begin
      r_pc       <= RESET_PC;
      r_pc_valid <= 1'b0;
      r_ptr      <= '0;
      r_count    <= '0;
    end else begin
      r_pc_valid <= 1'b1;
      if (bus.trap_i) begin
        r_pc    <= TRAP_VEC;
        r_ptr   <= '0;
        r_count <= '0;
      end else if (bus.redirect_i) begin
        r_pc <= w_redirect_pc;
      end else if (bus.stall_i) begin
        r_pc <= r_pc;
      end else if (w_pop) begin
        r_pc <= r_ras[w_top_idx];
        if (!bus.call_i) begin
          r_ptr   <= w_top_idx;
          r_count <= r_count - CNT_W'(1);
        end
      end else begin
        r_pc <= w_pc_seq;
        if (w_push) begin
          r_ptr <= r_ptr + PTR_W'(1);
          if (!w_full) r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: RAS storage has no reset; validity is tracked solely by r_count,
  // which keeps this a plain register file without a reset fan-out.
  always_ff @(posedge clk_i) begin
    if (w_push) r_ras[w_waddr] <= w_pc_seq;
  end

  assign bus.pc_o        = r_pc;
  assign bus.pc_valid_o  = r_pc_valid;
  assign bus.ras_count_o = r_count;
  assign bus.ras_empty_o = (r_count == '0);
  assign bus.ras_full_o  = w_full;
endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed-vector bench for pc_unit_ras with default parameters (depth 4, step 4, trap 0x100).
module tb_pc_unit_ras;
  logic clk_i;
  logic rst_n_i;
  int   n_checks;
  int   n_errors;

  pc_unit_ras_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

  pc_unit_ras #(
    .XLEN(32), .RESET_PC(32'h0), .TRAP_VEC(32'h100), .STEP(4), .RAS_DEPTH(4)
  ) dut (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.trap_i        = 1'b0;
    bus.call_i        = 1'b0;
    bus.ret_i         = 1'b0;
  endtask

  task automatic expect_pc(input string name, input logic [31:0] exp_pc, input int exp_cnt);
    n_checks++;
    if (bus.pc_o !== exp_pc) begin
      n_errors++;
      $display("FAIL %s pc_o got %h want %h", name, bus.pc_o, exp_pc);
    end
    n_checks++;
    if (bus.ras_count_o !== 3'(exp_cnt)) begin
      n_errors++;
      $display("FAIL %s ras_count_o got %0d want %0d", name, bus.ras_count_o, exp_cnt);
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = pc;
    tick();
    bus.redirect_i    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    bus.start_i = 1'b0;
    idle_inputs();
    #12;
    n_checks++;
    if (bus.pc_o !== 32'h0 || bus.pc_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset pc/valid got %h/%b want 0/0", bus.pc_o, bus.pc_valid_o);
    end
    n_checks++;
    if (bus.ras_count_o !== 3'd0 || bus.ras_empty_o !== 1'b1 || bus.ras_full_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset ras got cnt=%0d empty=%b full=%b want 0/1/0",
               bus.ras_count_o, bus.ras_empty_o, bus.ras_full_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_seq [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
    bus.start_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_pc($sformatf("seq%0d", i), exp_seq[i], 0);
      n_checks++;
      if (bus.pc_valid_o !== 1'b1) begin
        n_errors++;
        $display("FAIL seq%0d pc_valid_o got %b want 1", i, bus.pc_valid_o);
      end
    end
    // asynchronous reset in the middle of the cycle
    #2;
    rst_n_i = 1'b0;
    #1;
    n_checks++;
    if (bus.pc_o !== 32'h0 || bus.pc_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset pc/valid got %h/%b want 0/0", bus.pc_o, bus.pc_valid_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) tick();
    expect_pc("stall_pre", 32'h10, 0);
    bus.stall_i = 1'b1;
    bus.call_i  = 1'b1;
    tick();
    expect_pc("stall1", 32'h10, 0);
    tick();
    expect_pc("stall2", 32'h10, 0);
    idle_inputs();
    tick();
    expect_pc("stall_release", 32'h14, 0);
  endtask

  task automatic test_call_redirect_ret();
    redirect_to(32'h20);
    expect_pc("cr_redir20", 32'h20, 0);
    bus.call_i = 1'b1;
    tick();
    bus.call_i = 1'b0;
    expect_pc("cr_call", 32'h24, 1);
    redirect_to(32'h103);
    expect_pc("cr_redir_align", 32'h100, 1);
    bus.ret_i = 1'b1;
    tick();
    bus.ret_i = 1'b0;
    expect_pc("cr_ret", 32'h24, 0);
    n_checks++;
    if (bus.ras_empty_o !== 1'b1) begin
      n_errors++;
      $display("FAIL cr_empty ras_empty_o got %b want 1", bus.ras_empty_o);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_ret [5] = '{32'h14, 32'h10, 32'hC, 32'h8, 32'hC};
    int          exp_cnt [5] = '{3, 2, 1, 0, 0};
    redirect_to(32'h0);
    bus.call_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_pc($sformatf("ovf_call%0d", i), 32'(4 * (i + 1)), (i < 4) ? i + 1 : 4);
    end
    bus.call_i = 1'b0;
    n_checks++;
    if (bus.ras_full_o !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_full ras_full_o got %b want 1", bus.ras_full_o);
    end
    bus.ret_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_pc($sformatf("ovf_ret%0d", i), exp_ret[i], exp_cnt[i]);
    end
    bus.ret_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    redirect_to(32'h40);
    bus.call_i = 1'b1;
    tick();
    tick();
    expect_pc("b2b_calls", 32'h48, 2);
    // pop and push together: jump to top, rewrite slot with 0x4C
    bus.ret_i = 1'b1;
    tick();
    expect_pc("b2b_retcall", 32'h48, 2);
    bus.call_i = 1'b0;
    tick();
    expect_pc("b2b_ret", 32'h4C, 1);
    bus.ret_i  = 1'b0;
    bus.call_i = 1'b1;
    tick();
    bus.call_i = 1'b0;
    expect_pc("b2b_call", 32'h50, 2);
    bus.trap_i        = 1'b1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h200;
    bus.ret_i         = 1'b1;
    tick();
    idle_inputs();
    expect_pc("b2b_trap", 32'h100, 0);
  endtask

  task automatic test_wrap_and_stop();
    redirect_to(32'hFFFF_FFFC);
    expect_pc("wrap_pre", 32'hFFFF_FFFC, 0);
    bus.call_i = 1'b1;
    tick();
    bus.call_i = 1'b0;
    expect_pc("wrap", 32'h0, 1);
    bus.start_i = 1'b0;
    bus.ret_i   = 1'b1;
    tick();
    idle_inputs();
    expect_pc("stop", 32'h0, 0);
    n_checks++;
    if (bus.pc_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL stop pc_valid_o got %b want 0", bus.pc_valid_o);
    end
    bus.start_i = 1'b1;
    tick();
    expect_pc("restart", 32'h4, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_call_redirect_ret();
    test_overflow();
    test_back_to_back();
    test_wrap_and_stop();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
Parametrised program-counter unit for the IF stage; next generation of the single-register PC.
Selects the next fetch address with fixed priority: trap, branch redirect, stall hold, return prediction, sequential.
Contains a circular return-address stack (RAS) that predicts return targets from call/return hints supplied by fetch pre-decode.
Output feeds instruction memory and the IF/ID pipeline register.

Parameters:
XLEN, 32, PC and address width in bits
RESET_PC, 32'h0000_0000, value of pc_o after reset and while not started
TRAP_VEC, 32'h0000_0100, next PC when trap_i is taken
STEP, 4, sequential increment in bytes; power of two
RAS_DEPTH, 4, RAS entries; power of two, at least 2

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  run enable; 0 holds the PC at RESET_PC
stall_i  in  1  hazard stall; holds the PC
redirect_i  in  1  branch/jump resolved to a mispredicted target
redirect_pc_i  in  XLEN  corrected target address
trap_i  in  1  exception/trap taken
call_i  in  1  instruction at pc_o is a call
ret_i  in  1  instruction at pc_o is a return
pc_o  out  XLEN  current fetch address
pc_valid_o  out  1  pc_o is a live fetch address
ras_count_o  out  log2(RAS_DEPTH)+1  valid RAS entries
ras_empty_o  out  1  ras_count_o == 0
ras_full_o  out  1  ras_count_o == RAS_DEPTH

Behaviour:
- Reset (asynchronous assert, synchronous release): pc_o=RESET_PC, pc_valid_o=0, RAS pointer=0, ras_count_o=0, ras_empty_o=1, ras_full_o=0. RAS data contents are don't-care.
- All other state updates on the rising edge of clk_i.
- Edge with start_i=0:
  - pc_o<=RESET_PC, pc_valid_o<=0, RAS cleared.
  - All other inputs are ignored.
- Edge with start_i=1: pc_valid_o<=1. Next PC uses the first matching rule below:
  1. trap_i: pc_o<=TRAP_VEC; RAS cleared.
  2. redirect_i: pc_o<=redirect_pc_i with the low log2(STEP) bits forced to 0; RAS unchanged.
  3. stall_i: pc_o holds; RAS unchanged; call_i and ret_i are ignored.
  4. ret_i with RAS non-empty:
     - pc_o<=top entry (pop).
     - If call_i is also 1, the popped slot is rewritten with pc_o+STEP and the count is unchanged.
  5. Otherwise: pc_o<=pc_o+STEP, modulo 2^XLEN (0xFFFF_FFFC+4 gives 0).
     - ret_i with an empty RAS falls here; the count stays 0.
     - call_i (without a pop) pushes pc_o+STEP.
- RAS push when full: overwrite the oldest entry (circular); count stays RAS_DEPTH; the newest entry is the top.
- Pop after an overflow returns the most recent RAS_DEPTH addresses in LIFO order; the count then decrements normally.
- The PC is registered: a decision made at edge N is visible on pc_o after edge N. No combinational path exists from inputs to pc_o.
- ras_empty_o and ras_full_o are combinational decodes of the registered count.
- start_i falling mid-run: at the next edge the PC returns to RESET_PC and the RAS is flushed, the same as a start from cold.

Test Plan:
- Reset then start_i=1 for 4 edges, RESET_PC=0 -> pc_o 0,4,8,C,10. pc_valid_o=1 from edge 1. rst_n_i=0 mid-cycle -> pc_o=0 immediately.
- stall_i=1 at pc=0x10 for 2 edges, with call_i=1 also asserted -> pc_o stays 0x10, ras_count_o stays 0. After release -> 0x14.
- call_i at pc=0x20, then redirect_i with redirect_pc_i=0x103 -> pc_o=0x100, ras_count_o=1. ret_i at 0x100 -> pc_o=0x24, ras_count_o=0, ras_empty_o=1.
- 5 calls at 0x0,0x4,0x8,0xC,0x10 with depth 4 -> ras_full_o=1, count=4. Four rets -> targets 0x14,0x10,0xC,0x8. A fifth ret -> sequential, count stays 0.
- trap_i, redirect_i and ret_i all asserted in the same cycle, count=2 -> pc_o=0x100 (TRAP_VEC), ras_count_o=0.
- pc_o=0xFFFF_FFFC, no events -> pc_o=0x0. Then start_i=0 -> pc_o=0, pc_valid_o=0.
